// File: rtl/morse_tx_scheduler_if.sv
// Handshake bundle for morse_tx_scheduler: source request/grant/ack, encoder
// start/busy/done/bitstream, and the key/status outputs.
interface morse_tx_scheduler_if #(
  parameter int unsigned OUT_MAX_BITS = 256
);
  logic [1:0]              req;
  logic                    abort;
  logic [1:0]              grant;
  logic [1:0]              ack;
  logic                    enc_start;
  logic                    enc_busy;
  logic                    enc_done;
  logic [OUT_MAX_BITS-1:0] enc_bitstream;
  logic [8:0]              enc_bitlen;
  logic                    key_out;
  logic                    busy;
  logic                    err;

  // master: the scheduler; slave: sources, encoder and key consumer
  modport master (
    input  req, abort, enc_busy, enc_done, enc_bitstream, enc_bitlen,
    output grant, ack, enc_start, key_out, busy, err
  );

  modport slave (
    output req, abort, enc_busy, enc_done, enc_bitstream, enc_bitlen,
    input  grant, ack, enc_start, key_out, busy, err
  );
endinterface

// File: rtl/morse_tx_scheduler.sv
// Round-robin Morse message scheduler: arbitrates two sources, runs the shared
// encoder, then keys the latched bitstream with unit timing. Optional encoder
// watchdog enabled by defining MORSE_TX_WATCHDOG_EN.
module morse_tx_scheduler #(
  parameter int unsigned OUT_MAX_BITS = 256,
  parameter int unsigned UNIT_CYCLES  = 1000,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned WD_CYCLES    = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  morse_tx_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_ENC,
    S_WAIT_ENC,
    S_DECODE,
    S_KEY_ON,
    S_KEY_OFF,
    S_FINISH
  } state_t;

  localparam logic [CNT_W-1:0] UNIT_LAST = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  if (UNIT_CYCLES < 1 || UNIT_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_unit
    $error("morse_tx_scheduler: UNIT_CYCLES out of range for CNT_W");
  end
  if (WD_CYCLES < 1) begin : g_bad_wd
    $error("morse_tx_scheduler: WD_CYCLES must be at least 1");
  end

  state_t                  state;
  logic [1:0]              grant_q;
  logic [1:0]              ack_q;
  logic                    enc_start_q;
  logic                    key_q;
  logic                    busy_q;
  logic                    err_q;
  logic                    last_served;
  logic [OUT_MAX_BITS-1:0] shadow;
  logic [8:0]              len;
  logic [8:0]              ptr;
  logic [1:0]              units;
  logic [1:0]              off_units;
  logic [CNT_W-1:0]        cyc_cnt;
  logic                    wd_fire;

  logic [OUT_MAX_BITS-1:0] shifted;
  logic                    tok_b0;
  logic                    tok_b1;
  logic                    at_end;
  logic                    tok_trunc;

  always_comb begin
    shifted   = shadow >> ptr;
    tok_b0    = shifted[0];
    tok_b1    = shifted[1];
    at_end    = (ptr >= len);
    tok_trunc = (({1'b0, ptr} + 10'd1) >= {1'b0, len});
  end

`ifdef MORSE_TX_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WD_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  logic [WD_W-1:0] wd_cnt;

  assign wd_fire = (state == S_WAIT_ENC) && !bus.enc_done && (wd_cnt == WD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q  <= wd_fire;
      wd_cnt <= (state == S_WAIT_ENC) ? wd_cnt + WD_ONE : '0;
    end
  end
`else
  assign wd_fire = 1'b0;
  assign err_q   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      grant_q     <= '0;
      ack_q       <= '0;
      enc_start_q <= 1'b0;
      key_q       <= 1'b0;
      busy_q      <= 1'b0;
      last_served <= 1'b1;
      shadow      <= '0;
      len         <= '0;
      ptr         <= '0;
      units       <= '0;
      off_units   <= '0;
      cyc_cnt     <= '0;
    end else begin
      ack_q       <= '0;
      enc_start_q <= 1'b0;
      // Abort and watchdog share one exit: drop everything, no ack, rotate priority.
      if (state != S_IDLE && (bus.abort || wd_fire)) begin
        state       <= S_IDLE;
        key_q       <= 1'b0;
        grant_q     <= '0;
        busy_q      <= 1'b0;
        last_served <= grant_q[1];
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.req != 2'b00) begin
              busy_q  <= 1'b1;
              state   <= S_START_ENC;
              grant_q <= (bus.req == 2'b11) ? (last_served ? 2'b01 : 2'b10) : bus.req;
            end
          end
          S_START_ENC: begin
            if (!bus.enc_busy) begin
              enc_start_q <= 1'b1;
              state       <= S_WAIT_ENC;
            end
          end
          S_WAIT_ENC: begin
            if (bus.enc_done) begin
              shadow <= bus.enc_bitstream;
              len    <= (int'(bus.enc_bitlen) > OUT_MAX_BITS) ? 9'(OUT_MAX_BITS) : bus.enc_bitlen;
              ptr    <= '0;
              state  <= S_DECODE;
            end
          end
          S_DECODE: begin
            cyc_cnt <= '0;
            key_q   <= 1'b0;
            if (at_end) begin
              state <= S_FINISH;
            end else if (!tok_b0) begin
              key_q     <= 1'b1;
              units     <= 2'd0;
              off_units <= 2'd0;
              ptr       <= ptr + 9'd1;
              state     <= S_KEY_ON;
            end else if (tok_trunc) begin
              state <= S_FINISH;
            end else if (!tok_b1) begin
              key_q     <= 1'b1;
              units     <= 2'd2;
              off_units <= 2'd0;
              ptr       <= ptr + 9'd2;
              state     <= S_KEY_ON;
            end else begin
              units <= 2'd1;
              ptr   <= ptr + 9'd2;
              state <= S_KEY_OFF;
            end
          end
          // units holds remaining whole units minus one; cyc_cnt counts within a unit
          S_KEY_ON: begin
            if (cyc_cnt == UNIT_LAST) begin
              cyc_cnt <= '0;
              if (units == 2'd0) begin
                key_q <= 1'b0;
                units <= off_units;
                state <= S_KEY_OFF;
              end else begin
                units <= units - 2'd1;
              end
            end else begin
              cyc_cnt <= cyc_cnt + CNT_ONE;
            end
          end
          S_KEY_OFF: begin
            if (cyc_cnt == UNIT_LAST) begin
              cyc_cnt <= '0;
              if (units == 2'd0) begin
                state <= S_DECODE;
              end else begin
                units <= units - 2'd1;
              end
            end else begin
              cyc_cnt <= cyc_cnt + CNT_ONE;
            end
          end
          S_FINISH: begin
            ack_q       <= grant_q;
            grant_q     <= '0;
            last_served <= grant_q[1];
            busy_q      <= 1'b0;
            state       <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.grant     = grant_q;
  assign bus.ack       = ack_q;
  assign bus.enc_start = enc_start_q;
  assign bus.key_out   = key_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_morse_tx_scheduler.sv
// Self-checking bench for morse_tx_scheduler: symbol-level model of the key
// waveform, randomized messages, arbitration, abort and stale-handshake cases.
module tb_morse_tx_scheduler;
  localparam int unsigned OMB = 256;
  localparam int unsigned U   = 4;
  localparam int unsigned WD  = 16;

  localparam int DOT   = 0;
  localparam int DASH  = 1;
  localparam int LEND  = 2;
  localparam int SPACE = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  morse_tx_scheduler_if #(.OUT_MAX_BITS(OMB)) bus ();

  morse_tx_scheduler #(
    .OUT_MAX_BITS(OMB),
    .UNIT_CYCLES (U),
    .CNT_W       (4),
    .WD_CYCLES   (WD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int vectors = 0;
  int errors  = 0;
  int syms[$];
  bit trunc;
  bit exp_q[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OMB-1:0] junk();
    logic [OMB-1:0] v;
    for (int i = 0; i < OMB / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Bitstream from the symbol list, random junk above the valid length.
  function automatic void build(output logic [OMB-1:0] bits, output logic [8:0] len);
    int p = 0;
    bits = junk();
    foreach (syms[i]) begin
      case (syms[i])
        DOT:   begin bits[p] = 1'b0; p += 1; end
        DASH:  begin bits[p] = 1'b1; bits[p+1] = 1'b0; p += 2; end
        LEND:  begin bits[p] = 1'b1; bits[p+1] = 1'b1; p += 2; end
        default: begin bits[p +: 4] = 4'b1111; p += 4; end
      endcase
    end
    if (trunc) begin bits[p] = 1'b1; p += 1; end
    len = 9'(p);
  endfunction

  function automatic void push_n(bit v, int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endfunction

  // Expected key samples from the decode cycle after enc_done up to (not incl.) the ack cycle.
  function automatic void model();
    exp_q.delete();
    foreach (syms[i]) begin
      case (syms[i])
        DOT:   begin push_n(0, 1); push_n(1, U);     push_n(0, U); end
        DASH:  begin push_n(0, 1); push_n(1, 3 * U); push_n(0, U); end
        LEND:  begin push_n(0, 1); push_n(0, 2 * U); end
        default: begin push_n(0, 1); push_n(0, 2 * U); push_n(0, 1); push_n(0, 2 * U); end
      endcase
    end
    push_n(0, 2);
  endfunction

  task automatic do_reset;
    rst_n = 1'b0;
    bus.req = '0; bus.abort = 1'b0;
    bus.enc_busy = 1'b0; bus.enc_done = 1'b0;
    bus.enc_bitstream = '0; bus.enc_bitlen = '0;
    repeat (3) tick;
    rst_n = 1'b1;
  endtask

  task automatic serve_one(input logic [1:0] exp_grant, input bit drop,
                           input int abort_on, input bit stale, input string name);
    logic [OMB-1:0] bits;
    logic [8:0] len;
    int n, early, pulses, ones_seen, ones_exp, kerr, stable_err;
    bit got[$];
    build(bits, len);
    model();
    ones_exp = 0;
    foreach (exp_q[i]) ones_exp += int'(exp_q[i]);
    n = 0;
    while (bus.grant == 2'b00 && n < 8) begin tick; n++; end
    vectors++;
    if (bus.grant !== exp_grant) begin
      errors++; $display("FAIL %s grant: got %b want %b", name, bus.grant, exp_grant);
    end
    early = 0;
    bus.enc_busy = 1'b1;
    repeat (stale ? 2 : $urandom_range(0, 3)) begin
      if (stale) begin bus.enc_done = 1'b1; bus.enc_bitstream = junk(); bus.enc_bitlen = 9'd40; end
      tick;
      bus.enc_done = 1'b0;
      early += int'(bus.enc_start);
    end
    bus.enc_busy = 1'b0;
    n = 0;
    while (!bus.enc_start && n < 10) begin tick; n++; end
    vectors++;
    if (early !== 0 || bus.enc_start !== 1'b1) begin
      errors++; $display("FAIL %s enc_start: early=%0d seen=%b want early=0 seen=1", name, early, bus.enc_start);
    end
    pulses = 0;
    bus.enc_busy = 1'b1;
    repeat ($urandom_range(1, 4)) begin tick; pulses += int'(bus.enc_start); end
    bus.enc_bitstream = bits; bus.enc_bitlen = len;
    bus.enc_done = 1'b1; bus.enc_busy = 1'b0;
    tick;
    pulses += int'(bus.enc_start);
    bus.enc_done = 1'b0; bus.enc_bitstream = junk(); bus.enc_bitlen = 9'($urandom);
    ones_seen = 0; stable_err = 0; n = 0;
    while (bus.ack == 2'b00 && n < 3000) begin
      got.push_back(bus.key_out);
      ones_seen += int'(bus.key_out);
      if (bus.grant !== exp_grant || bus.busy !== 1'b1) stable_err++;
      pulses += int'(bus.enc_start);
      if (abort_on > 0 && ones_seen == abort_on) begin
        bus.abort = 1'b1;
        tick;
        bus.abort = 1'b0;
        vectors++;
        if (bus.key_out !== 1'b0 || bus.grant !== 2'b00 || bus.busy !== 1'b0 || bus.ack !== 2'b00) begin
          errors++; $display("FAIL %s abort: key=%b grant=%b busy=%b ack=%b want all 0", name,
                             bus.key_out, bus.grant, bus.busy, bus.ack);
        end
        tick;
        vectors++;
        if (bus.grant !== exp_grant || bus.ack !== 2'b00) begin
          errors++; $display("FAIL %s regrant: grant=%b ack=%b want grant=%b ack=00", name,
                             bus.grant, bus.ack, exp_grant);
        end
        return;
      end
      tick;
      n++;
    end
    vectors++;
    if (bus.ack !== exp_grant) begin
      errors++; $display("FAIL %s ack: got %b want %b", name, bus.ack, exp_grant);
    end
    vectors++;
    if (got.size() != exp_q.size()) begin
      errors++; $display("FAIL %s cycles_to_ack: got %0d want %0d", name, got.size(), exp_q.size());
    end
    kerr = 0;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] != exp_q[i]) kerr++;
    vectors++;
    if (kerr != 0) begin
      errors++; $display("FAIL %s key_waveform: %0d differing cycles want 0", name, kerr);
    end
    vectors++;
    if (ones_seen != ones_exp) begin
      errors++; $display("FAIL %s key_high_cycles: got %0d want %0d", name, ones_seen, ones_exp);
    end
    vectors++;
    if (stable_err != 0 || pulses != 0) begin
      errors++; $display("FAIL %s playback: unstable=%0d extra_starts=%0d want 0/0", name, stable_err, pulses);
    end
    vectors++;
    if (bus.grant !== 2'b00 || bus.busy !== 1'b0 || bus.key_out !== 1'b0 || bus.err !== 1'b0) begin
      errors++; $display("FAIL %s at_ack: grant=%b busy=%b key=%b err=%b want 00/0/0/0", name,
                         bus.grant, bus.busy, bus.key_out, bus.err);
    end
    if (drop) bus.req = bus.req & ~exp_grant;
    tick;
    vectors++;
    if (bus.ack !== 2'b00) begin
      errors++; $display("FAIL %s ack_pulse: got %b want 00", name, bus.ack);
    end
  endtask

  task automatic test_reset;
    do_reset;
    for (int i = 0; i < 10; i++) begin
      tick;
      vectors++;
      if ({bus.grant, bus.ack, bus.enc_start, bus.key_out, bus.busy, bus.err} !== 8'd0) begin
        errors++; $display("FAIL reset_idle cycle %0d: outputs=%b want 00000000", i,
                           {bus.grant, bus.ack, bus.enc_start, bus.key_out, bus.busy, bus.err});
      end
    end
  endtask

  task automatic test_letters;
    syms = '{DOT, LEND}; trunc = 0; bus.req = 2'b01;
    serve_one(2'b01, 1, 0, 0, "letter_E");
    syms = '{DASH, LEND}; trunc = 0; bus.req = 2'b01;
    serve_one(2'b01, 1, 0, 0, "letter_T");
  endtask

  task automatic test_boundaries;
    syms = {}; trunc = 0; bus.req = 2'b10;
    serve_one(2'b10, 1, 0, 0, "empty");
    syms = '{DOT, DASH}; trunc = 1; bus.req = 2'b01;
    serve_one(2'b01, 1, 0, 0, "truncated");
    syms = '{DOT, LEND, SPACE, DASH, LEND}; trunc = 0; bus.req = 2'b10;
    serve_one(2'b10, 1, 0, 1, "stale_done");
  endtask

  task automatic test_round_robin;
    do_reset;
    tick;
    syms = '{DOT, LEND}; trunc = 0; bus.req = 2'b11;
    serve_one(2'b01, 1, 0, 0, "rr_first");
    serve_one(2'b10, 1, 0, 0, "rr_second");
    bus.req = 2'b11;
    serve_one(2'b01, 0, 0, 0, "rr_hold0");
    serve_one(2'b10, 1, 0, 0, "rr_other_wins");
    serve_one(2'b01, 1, 0, 0, "rr_held_again");
  endtask

  task automatic test_abort;
    syms = '{DASH, LEND}; trunc = 0; bus.req = 2'b01;
    serve_one(2'b01, 0, 5, 0, "abort_dash");
    serve_one(2'b01, 1, 0, 0, "after_abort");
  endtask

  task automatic test_random;
    for (int k = 0; k < 8; k++) begin
      logic [1:0] src;
      syms.delete();
      repeat ($urandom_range(0, 10)) syms.push_back(int'($urandom_range(0, 3)));
      trunc = bit'($urandom_range(0, 1));
      src = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      bus.req = src;
      serve_one(src, 1, 0, 0, "random");
    end
  endtask

`ifdef MORSE_TX_WATCHDOG_EN
  task automatic test_watchdog;
    int n, early;
    bus.req = 2'b01; bus.enc_busy = 1'b0;
    n = 0;
    while (!bus.enc_start && n < 10) begin tick; n++; end
    early = 0;
    for (int i = 0; i < WD - 1; i++) begin tick; early += int'(bus.err); end
    tick;
    vectors++;
    if (early != 0 || bus.err !== 1'b1 || bus.ack !== 2'b00 || bus.grant !== 2'b00 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL watchdog: early=%0d err=%b ack=%b grant=%b busy=%b want 0/1/00/00/0",
                         early, bus.err, bus.ack, bus.grant, bus.busy);
    end
    bus.req = 2'b00;
    tick;
    vectors++;
    if (bus.err !== 1'b0) begin
      errors++; $display("FAIL watchdog_pulse: err=%b want 0", bus.err);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_letters;
    test_boundaries;
    test_round_robin;
    test_abort;
    test_random;
`ifdef MORSE_TX_WATCHDOG_EN
    test_watchdog;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
